md_iter_unit: RTL

Parametrised iterative multiply/divide unit for the execute stage. It generalises the combinational ALU into a WIDTH-bit, one-bit-per-cycle engine. It owns the HI/LO architectural registers and exposes a busy flag so the hazard controller can stall MD-class instructions. It sits beside the ALU in E and is written by the same opcode-decode path.

---
 rtl/md_iter_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/md_iter_unit.sv
// Iterative radix-2 multiply/divide unit owning HI/LO; one step per cycle.
// Define MD_ITER_MACC_EN to enable MADD/MADDU/MSUB/MSUBU (ops 6..9).
module md_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_RUN} state_t;
  typedef enum logic [1:0] {M_MUL, M_DIV, M_MADD, M_MSUB} mode_t;

  state_t state_q, state_d;
  mode_t  mode_q, mode_d;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               pneg_q, pneg_d;
  logic               rneg_q, rneg_d;

  logic               sgn_in;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_sum, sh_rem, sub_diff;
  logic [2*WIDTH-1:0] mul_p, div_p, step_p, prod;
  logic [WIDTH-1:0]   quo_s, rem_s;
  logic               last;
`ifdef MD_ITER_MACC_EN
  logic [2*WIDTH-1:0] acc_res;
`endif

  // p_q holds {partial, multiplier} for MUL and {remainder, quotient} for DIV
  always_comb begin
    sgn_in = ~op[0];
    a_mag  = (sgn_in && a[WIDTH-1]) ? -a : a;
    b_mag  = (sgn_in && b[WIDTH-1]) ? -b : b;

    add_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]}
            + {1'b0, (p_q[0] ? d_q : '0)};
    mul_p   = {add_sum, p_q[WIDTH-1:1]};

    sh_rem   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    sub_diff = sh_rem - {1'b0, d_q};
    div_p    = sub_diff[WIDTH]
             ? {sh_rem[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
             : {sub_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};

    step_p = (mode_q == M_DIV) ? div_p : mul_p;
    prod   = pneg_q ? -step_p : step_p;
    quo_s  = pneg_q ? -step_p[WIDTH-1:0] : step_p[WIDTH-1:0];
    rem_s  = rneg_q ? -step_p[2*WIDTH-1:WIDTH]
                    : step_p[2*WIDTH-1:WIDTH];
`ifdef MD_ITER_MACC_EN
    acc_res = (mode_q == M_MSUB) ? ({hi_q, lo_q} - prod)
                                 : ({hi_q, lo_q} + prod);
`endif
    last = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    d_d     = d_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pneg_d  = pneg_q;
    rneg_d  = rneg_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            4'd0, 4'd1: begin
              state_d = S_RUN;
              mode_d  = M_MUL;
              p_d     = {{WIDTH{1'b0}}, b_mag};
              d_d     = a_mag;
            end
            4'd2, 4'd3: begin
              state_d = S_RUN;
              mode_d  = M_DIV;
              p_d     = {{WIDTH{1'b0}}, a_mag};
              d_d     = b_mag;
            end
            4'd4: hi_d = a;
            4'd5: lo_d = a;
`ifdef MD_ITER_MACC_EN
            4'd6, 4'd7, 4'd8, 4'd9: begin
              state_d = S_RUN;
              mode_d  = op[3] ? M_MSUB : M_MADD;
              p_d     = {{WIDTH{1'b0}}, b_mag};
              d_d     = a_mag;
            end
`endif
            default: ;
          endcase
          if (state_d == S_RUN) begin
            cnt_d  = '0;
            a_d    = a;
            pneg_d = sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_d = sgn_in & a[WIDTH-1];
          end
        end
      end
      S_RUN: begin
        p_d   = step_p;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          unique case (mode_q)
            M_DIV: begin
              if (d_q == '0) begin
                lo_d = '1;
                hi_d = a_q;
              end else begin
                lo_d = quo_s;
                hi_d = rem_s;
              end
            end
`ifdef MD_ITER_MACC_EN
            M_MADD, M_MSUB: {hi_d, lo_d} = acc_res;
`endif
            default: {hi_d, lo_d} = prod;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mode_q  <= M_MUL;
      cnt_q   <= '0;
      p_q     <= '0;
      d_q     <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      d_q     <= d_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pneg_q  <= pneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
